// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle between a requesting block and the bit-serial adder controller.
// The requester drives the operands and start, and the controller returns busy, done and the result.
interface serial_adder_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, op, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, op, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller. It steps two WIDTH-bit operands LSB-first through
// one full-adder cell and feeds the registered carry back into the cell on each clock.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_adder_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   sh_a_q, sh_a_d;
  logic [WIDTH-1:0]   sh_b_q, sh_b_d;
  logic [WIDTH-2:0]   sh_s_q, sh_s_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;

  logic               bit_s_c;
  logic               bit_carry_c;
  logic               last_c;

  // The shared full-adder cell
  assign bit_s_c     = sh_a_q[0] ^ sh_b_q[0] ^ carry_q;
  assign bit_carry_c = (sh_a_q[0] & sh_b_q[0]) | (sh_a_q[0] & carry_q) | (sh_b_q[0] & carry_q);
  assign last_c      = (cnt_q == CNT_W'(WIDTH - 1));

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      sh_s_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      sh_s_q  <= sh_s_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Next-state and datapath update. DONE accepts a new start the same way IDLE does,
  // so back-to-back operations run with no gap cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    sh_s_d  = sh_s_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          // Subtract is computed as a + ~b + 1.
          sh_a_d  = bus.a;
          sh_b_d  = bus.op ? ~bus.b : bus.b;
          carry_d = bus.op ? 1'b1 : bus.cin;
          cnt_d   = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end

      RUN: begin
        carry_d = bit_carry_c;
        sh_a_d  = {1'b0, sh_a_q[WIDTH-1:1]};
        sh_b_d  = {1'b0, sh_b_q[WIDTH-1:1]};
        sh_s_d  = (WIDTH-1)'({bit_s_c, sh_s_q} >> 1);
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_c) begin
          state_d = DONE;
          done_d  = 1'b1;
          sum_d   = {bit_s_c, sh_s_q};
          cout_d  = bit_carry_c;
        end else begin
          busy_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule
